// File: rtl/div_issue.sv
// div_issue: issue/sequencing front-end for the radix-2 SRT divider.
// Define DIV_RESULT_CACHE_EN to add a one-entry divider result cache.
module div_issue #(
  parameter int N     = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_funct3,
  input  logic [N-1:0]     req_rs1,
  input  logic [N-1:0]     req_rs2,
  input  logic [TAG_W-1:0] req_rd,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N-1:0]     rsp_data,
  output logic [TAG_W-1:0] rsp_rd,
  output logic             div_rst,
  output logic [N-1:0]     div_dividend,
  output logic [N-1:0]     div_divisor,
  output logic [1:0]       div_op,
  input  logic [N-1:0]     div_out,
  input  logic             div_done,
  output logic             busy
);

  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] ONES    = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state, state_nx;
  logic           first;
  logic           accept;
  logic           capture;
  logic           special;
  logic           ovf;
  logic           hit;
  logic [1:0]     req_op;
  logic [N-1:0]   fast_data;
  logic [N-1:0]   cache_data;

  assign req_op  = req_funct3[1:0];
  assign accept  = (state == IDLE) && req_valid && !flush;
  // done is only trusted after the divider has seen one cycle out of reset
  assign capture = (state == RUN) && !first && div_done && !flush;
  assign ovf     = req_funct3[2] && !req_op[0] &&
                   (req_rs1 == MIN_NEG) && (req_rs2 == ONES);

  always_comb begin
    special   = 1'b0;
    fast_data = '0;
    unique case (1'b1)
      !req_funct3[2]: special = 1'b1;
      req_funct3[2] && (req_rs2 == '0): begin
        special   = 1'b1;
        fast_data = req_op[1] ? req_rs1 : ONES;
      end
      ovf: begin
        special   = 1'b1;
        fast_data = req_op[1] ? '0 : MIN_NEG;
      end
      default: ;
    endcase
  end

`ifdef DIV_RESULT_CACHE_EN
  logic           c_valid;
  logic [N-1:0]   c_rs1;
  logic [N-1:0]   c_rs2;
  logic [N-1:0]   c_data;
  logic [1:0]     c_op;

  assign hit = c_valid && (c_rs1 == req_rs1) &&
               (c_rs2 == req_rs2) && (c_op == req_op);
  assign cache_data = c_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_valid <= 1'b0;
      c_rs1   <= '0;
      c_rs2   <= '0;
      c_data  <= '0;
      c_op    <= '0;
    end else if (flush) begin
      c_valid <= 1'b0;
    end else if (capture) begin
      c_valid <= 1'b1;
      c_rs1   <= div_dividend;
      c_rs2   <= div_divisor;
      c_op    <= div_op;
      c_data  <= div_out;
    end
  end
`else
  assign hit        = 1'b0;
  assign cache_data = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = (special || hit) ? RESP : RUN;
      RUN:     if (!first && div_done) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_rst      <= 1'b1;
      first        <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      div_op       <= '0;
      rsp_data     <= '0;
      rsp_rd       <= '0;
    end else begin
      div_rst <= (state_nx != RUN);
      first   <= accept;
      if (accept) begin
        div_dividend <= req_rs1;
        div_divisor  <= req_rs2;
        div_op       <= req_op;
        rsp_rd       <= req_rd;
        if (special)  rsp_data <= fast_data;
        else if (hit) rsp_data <= cache_data;
      end
      if (capture) rsp_data <= div_out;
    end
  end

endmodule
